// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port with a req/ready handshake, counts retired instructions, traps on bad opcodes.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       fun,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             illegal,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic is_rtype, is_jr, is_legal;

  assign is_rtype = (op == OP_RTYPE);
  assign is_jr    = is_rtype && (fun == FN_JR);

  always_comb begin
    is_legal = 1'b0;
    if (is_rtype) begin
      is_legal = (fun == FN_ADDU) || (fun == FN_SUBU) || (fun == FN_JR) || (fun == FN_SLL);
    end else begin
      case (op)
        OP_J, OP_JAL, OP_BEQ, OP_ORI, OP_LUI, OP_LW, OP_SW: is_legal = 1'b1;
        default:                                            is_legal = 1'b0;
      endcase
    end
  end

  // NOTE: every output and state_d gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_sel = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    mdr_we  = 1'b0;
    pc_we   = 1'b0;
    npc_sel = 2'd0;
    reg_we  = 1'b0;
    reg_dst = 2'd0;
    wd_sel  = 2'd0;
    alu_src = 1'b0;
    alu_op  = 3'd0;
    ext_op  = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!is_legal) begin
          state_d = S_TRAP;
        end else if (op == OP_J || op == OP_JAL) begin
          pc_we   = 1'b1;
          npc_sel = 2'd2;
          state_d = S_FETCH;
          if (op == OP_JAL) begin
            reg_we  = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
        end else if (is_jr) begin
          pc_we   = 1'b1;
          npc_sel = 2'd3;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op)
          OP_RTYPE: begin
            alu_op  = (fun == FN_SUBU) ? 3'd1 : 3'd0;
            state_d = S_WB;
          end
          OP_ORI, OP_LUI: begin
            alu_src = 1'b1;
            ext_op  = (op == OP_LUI) ? 2'd2 : 2'd0;
            alu_op  = 3'd2;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            ext_op  = 2'd1;
            state_d = S_MEM;
          end
          default: begin
            // Only beq can reach here; the branch resolves from the subtract's zero flag.
            alu_op  = 3'd1;
            ext_op  = 2'd1;
            pc_we   = 1'b1;
            npc_sel = zero ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (op == OP_SW);
        if (mem_ready) begin
          if (op == OP_SW) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = is_rtype ? 2'd1 : 2'd0;
        wd_sel  = (op == OP_LW) ? 2'd1 : 2'd0;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_FETCH;
    endcase

    // Reset must silence the request and enables combinationally, even mid-access.
    if (!reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      mdr_we  = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pc_we) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign illegal   = (state_q == S_TRAP);
  assign state_o   = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: an instruction-level model expands each instruction into its
// expected per-cycle control vector; a 3-bit-counter instance exercises the wrap.
module tb_mc_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_sel;
    logic       mem_we;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       illegal;
    logic [2:0] state;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fun;
    logic       z;
    logic       rdy;
    ctl_t       e;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, fun;
  logic        zero, mem_ready;
  logic        mem_req, mem_sel, mem_we, ir_we, mdr_we, pc_we, reg_we, alu_src, illegal;
  logic [1:0]  npc_sel, reg_dst, wd_sel, ext_op;
  logic [2:0]  alu_op, state_o;
  logic [31:0] instr_cnt;

  logic        s_mem_req, s_mem_sel, s_mem_we, s_ir_we, s_mdr_we, s_pc_we, s_reg_we, s_alu_src, s_illegal;
  logic [1:0]  s_npc_sel, s_reg_dst, s_wd_sel, s_ext_op;
  logic [2:0]  s_alu_op, s_state_o;
  logic [2:0]  s_instr_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_cnt = 0;
  cyc_t q[$];

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .fun(fun), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_we(ir_we), .mdr_we(mdr_we),
    .pc_we(pc_we), .npc_sel(npc_sel), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .illegal(illegal),
    .state_o(state_o), .instr_cnt(instr_cnt)
  );

  mc_ctrl #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .op(op), .fun(fun), .zero(zero), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .mem_sel(s_mem_sel), .mem_we(s_mem_we), .ir_we(s_ir_we), .mdr_we(s_mdr_we),
    .pc_we(s_pc_we), .npc_sel(s_npc_sel), .reg_we(s_reg_we), .reg_dst(s_reg_dst), .wd_sel(s_wd_sel),
    .alu_src(s_alu_src), .alu_op(s_alu_op), .ext_op(s_ext_op), .illegal(s_illegal),
    .state_o(s_state_o), .instr_cnt(s_instr_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic ctl_t dut_ctl();
    return '{mem_req, mem_sel, mem_we, ir_we, mdr_we, pc_we, npc_sel, reg_we, reg_dst,
             wd_sel, alu_src, alu_op, ext_op, illegal, state_o};
  endfunction

  function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) return f inside {6'h21, 6'h23, 6'h08, 6'h00};
    return o inside {6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
  endfunction

  task automatic add_cyc(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input logic r, input ctl_t e);
    cyc_t c;
    c.op = o; c.fun = f; c.z = z; c.rdy = r; c.e = e;
    q.push_back(c);
  endtask

  // Expand one instruction into its cycle-by-cycle expected controls.
  // fw/mw: wait cycles before mem_ready in FETCH/MEM. Trapping ops get trap_cycles of TRAP.
  task automatic gen(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input int fw, input int mw, input int trap_cycles);
    ctl_t e;
    bit   rt = (o == 6'h00);
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.state = 3'd0; e.mem_req = 1'b1; e.ir_we = (i == fw);
      add_cyc(o, f, z, i == fw, e);
    end
    e = '0; e.state = 3'd1;
    if (!legal(o, f)) begin
      add_cyc(o, f, z, 1'b1, e);
      for (int i = 0; i < trap_cycles; i++) begin
        e = '0; e.state = 3'd7; e.illegal = 1'b1;
        add_cyc(o, f, z, 1'b1, e);
      end
      return;
    end
    if (o == 6'h02 || o == 6'h03 || (rt && f == 6'h08)) begin
      e.pc_we = 1'b1;
      e.npc_sel = (o == 6'h00) ? 2'd3 : 2'd2;
      if (o == 6'h03) begin e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2; end
      add_cyc(o, f, z, 1'b1, e);
      return;
    end
    add_cyc(o, f, z, 1'b1, e);
    e = '0; e.state = 3'd2;
    if (rt) e.alu_op = (f == 6'h23) ? 3'd1 : 3'd0;
    else if (o == 6'h0D) begin e.alu_src = 1'b1; e.ext_op = 2'd0; e.alu_op = 3'd2; end
    else if (o == 6'h0F) begin e.alu_src = 1'b1; e.ext_op = 2'd2; e.alu_op = 3'd2; end
    else if (o == 6'h23 || o == 6'h2B) begin e.alu_src = 1'b1; e.ext_op = 2'd1; end
    else begin e.alu_op = 3'd1; e.ext_op = 2'd1; e.pc_we = 1'b1; e.npc_sel = {1'b0, z}; end
    add_cyc(o, f, z, 1'b1, e);
    if (o == 6'h04) return;
    if (o == 6'h23 || o == 6'h2B) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.mem_sel = 1'b1; e.mem_we = (o == 6'h2B);
        if (i == mw) begin
          if (o == 6'h2B) e.pc_we = 1'b1;
          else            e.mdr_we = 1'b1;
        end
        add_cyc(o, f, z, i == mw, e);
      end
      if (o == 6'h2B) return;
    end
    e = '0; e.state = 3'd4; e.reg_we = 1'b1; e.pc_we = 1'b1;
    e.reg_dst = rt ? 2'd1 : 2'd0;
    e.wd_sel  = (o == 6'h23) ? 2'd1 : 2'd0;
    add_cyc(o, f, z, 1'b1, e);
  endtask

  // Single compare process: entered at posedge+2 (or later in the same cycle), drains the queue.
  task automatic run();
    while (q.size() > 0) begin
      cyc_t c = q.pop_front();
      op = c.op; fun = c.fun; zero = c.z; mem_ready = c.rdy;
      #3;
      check("ctl_vector", 64'(dut_ctl()), 64'(c.e));
      check("instr_cnt", 64'(instr_cnt), 64'(model_cnt));
      check("instr_cnt_w3", 64'(s_instr_cnt), 64'(model_cnt % 8));
      if (c.e.pc_we) model_cnt++;
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_cnt", 64'(instr_cnt), 64'd0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    model_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; op = 6'h00; fun = 6'h21; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #2;
    do_reset();

    // addu with zero-wait memory: 4 cycles, one retirement
    gen(6'h00, 6'h21, 1'b0, 0, 0, 0);
    check("addu_latency", 64'(q.size()), 64'd4);
    run();
    check("addu_cnt", 64'(instr_cnt), 64'd1);

    // lw with 3 wait cycles in MEM: 8 cycles
    gen(6'h23, 6'h00, 1'b0, 0, 3, 0);
    check("lw_latency", 64'(q.size()), 64'd8);
    run();

    // beq taken, then not taken with a fetch wait
    gen(6'h04, 6'h00, 1'b1, 0, 0, 0);
    check("beq_latency", 64'(q.size()), 64'd3);
    gen(6'h04, 6'h00, 1'b0, 1, 0, 0);
    run();

    // jumps
    gen(6'h03, 6'h00, 1'b0, 0, 0, 0);
    check("jal_latency", 64'(q.size()), 64'd2);
    gen(6'h02, 6'h00, 1'b0, 0, 0, 0);
    gen(6'h00, 6'h08, 1'b0, 0, 0, 0);
    run();

    // remaining instruction mix
    gen(6'h00, 6'h23, 1'b0, 2, 0, 0);
    gen(6'h0D, 6'h00, 1'b0, 0, 0, 0);
    gen(6'h0F, 6'h00, 1'b0, 0, 0, 0);
    gen(6'h2B, 6'h00, 1'b0, 0, 1, 0);
    gen(6'h00, 6'h00, 1'b0, 0, 0, 0);
    run();
    check("mix_cnt", 64'(instr_cnt), 64'd12);
    check("mix_cnt_w3_wrapped", 64'(s_instr_cnt), 64'd4);

    // bad opcode traps; counter frozen, no further requests
    gen(6'h3F, 6'h00, 1'b0, 0, 0, 5);
    run();
    check("trap_illegal", 64'(illegal), 64'd1);
    check("trap_cnt_frozen", 64'(instr_cnt), 64'd12);
    do_reset();

    // bad function under op 0 traps too
    gen(6'h00, 6'h3F, 1'b0, 0, 0, 3);
    run();
    do_reset();

    // reset during MEM of sw
    gen(6'h2B, 6'h00, 1'b0, 0, 3, 0);
    while (q.size() > 4) void'(q.pop_back());
    run();
    mem_ready = 1'b0;
    #1;
    check("sw_mem_we_held", 64'(mem_we), 64'd1);
    check("sw_state_mem", 64'(state_o), 64'd3);
    reset = 1'b0;
    #1;
    check("sw_mem_we_drop", 64'(mem_we), 64'd0);
    check("sw_pc_we_drop", 64'(pc_we), 64'd0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    model_cnt = 0;
    #1;
    check("post_rst_state", 64'(state_o), 64'd0);
    check("post_rst_cnt", 64'(instr_cnt), 64'd0);
    gen(6'h00, 6'h21, 1'b0, 0, 0, 0);
    run();
    check("post_rst_addu_cnt", 64'(instr_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
